// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared constants and enums for the expression operand loader
package expr_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int NUM_OPS   = 8;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_X = 3'd0,
    OP_Y = 3'd1,
    OP_Z = 3'd2,
    OP_P = 3'd3,
    OP_Q = 3'd4,
    OP_R = 3'd5,
    OP_S = 3'd6,
    OP_T = 3'd7
  } op_idx_t;
endpackage

// File: rtl/expr_operand_loader.sv
// rtl/expr_operand_loader.sv - collects an 8-word frame into the X..T operand bundle
// Optional EXPR_LOADER_ZERO_FILL_EN: short frames are zero-padded instead of flagged.
module expr_operand_loader
  import expr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] T,
  output logic             err_short,
  output logic             err_long
);
  localparam logic [1:0] S_FILL  = ST_FILL;
  localparam logic [1:0] S_FULL  = ST_FULL;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] LAST_IDX = 3'(NUM_OPS - 1);

  logic [1:0]       state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] ops [NUM_OPS];
  logic             beat;

  assign beat = in_valid && in_ready;

  assign X = ops[OP_X];
  assign Y = ops[OP_Y];
  assign Z = ops[OP_Z];
  assign P = ops[OP_P];
  assign Q = ops[OP_Q];
  assign R = ops[OP_R];
  assign S = ops[OP_S];
  assign T = ops[OP_T];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FILL;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) ops[i] <= '0;
    end else begin
      // in_ready follows the next state: low only while a bundle is pending
      in_ready  <= 1'b1;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        S_FILL: begin
          if (beat) begin
            ops[cnt] <= in_data;
            if (in_last) begin
              cnt <= '0;
              if (cnt == LAST_IDX) begin
                state     <= S_FULL;
                out_valid <= 1'b1;
                in_ready  <= 1'b0;
              end else begin
`ifdef EXPR_LOADER_ZERO_FILL_EN
                for (int i = 0; i < NUM_OPS; i++)
                  if (3'(i) > cnt) ops[i] <= '0;
                state     <= S_FULL;
                out_valid <= 1'b1;
                in_ready  <= 1'b0;
`else
                err_short <= 1'b1;
`endif
              end
            end else if (cnt == LAST_IDX) begin
              cnt      <= '0;
              state    <= S_DRAIN;
              err_long <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        S_FULL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FILL;
          end else begin
            in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (beat && in_last) state <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_expr_operand_loader.sv
// tb/tb_expr_operand_loader.sv - scoreboard bench for expr_operand_loader
module tb_expr_operand_loader;
  localparam int W = 32;
  localparam int K_BUNDLE = 0;
  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;

  typedef struct packed {
    logic [1:0]        kind;
    logic [7:0][W-1:0] vals;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] X, Y, Z, P, Q, R, S, T;
  logic err_short, err_long;

  int total = 0;
  int passed = 0;
  exp_t sb[$];

  expr_operand_loader #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .X(X), .Y(Y), .Z(Z), .P(P), .Q(Q), .R(R),
    .S(S), .T(T), .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_bundle(input logic [7:0][W-1:0] v);
    exp_t e;
    e.kind = 2'(K_BUNDLE);
    e.vals = v;
    sb.push_back(e);
  endtask

  task automatic push_err(input int k);
    exp_t e;
    e.kind = 2'(k);
    e.vals = '0;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(n), 64'd0);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] base, input int len);
    for (int i = 0; i < len; i++) send(base + W'(i), i == len - 1);
    idle();
  endtask

  // Monitor: samples 1 time unit after each negedge, far from the active edge.
  initial begin
    logic [W-1:0] got [8];
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (err_short && err_long) check("err_both", 64'd1, 64'd0);
      if ((out_valid && out_ready) || err_short || err_long) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {61'd0, out_valid, err_short, err_long}, 64'd0);
        end else begin
          e = sb.pop_front();
          if (e.kind == 2'(K_BUNDLE)) begin
            check("bundle_valid", 64'(out_valid && out_ready), 64'd1);
            got = '{X, Y, Z, P, Q, R, S, T};
            for (int i = 0; i < 8; i++)
              check($sformatf("bundle_op%0d", i), 64'(got[i]), 64'(e.vals[i]));
          end else if (e.kind == 2'(K_SHORT)) begin
            check("err_short_pulse", {62'd0, err_short, err_long}, 64'd2);
          end else begin
            check("err_long_pulse", {62'd0, err_short, err_long}, 64'd1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_X", 64'(X), 64'd0);
    check("rst_errs", {62'd0, err_short, err_long}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Basic frame 1..8
    out_ready = 1'b1;
    push_bundle({32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    for (int i = 1; i <= 8; i++) send(W'(i), i == 8);
    check("out_valid_latency", 64'(out_valid), 64'd1);
    check("in_ready_full", 64'(in_ready), 64'd0);
    idle();
    @(negedge clk);
    check("out_valid_after_hs", 64'(out_valid), 64'd0);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);

    // Backpressure: hold for 5 cycles with in_valid asserted
    out_ready = 1'b0;
    push_bundle({32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10});
    for (int i = 0; i < 8; i++) send(32'h10 + W'(i), i == 7);
    in_valid = 1'b1;
    in_data  = 32'hFF;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_X", 64'(X), 64'h10);
      check("bp_T", 64'(T), 64'h17);
      @(negedge clk);
    end
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 64'(out_valid), 64'd0);

    // Long frame of 10 words, then a good frame
    push_err(K_LONG);
    send_frame(32'h20, 10);
    check("long_no_valid", 64'(out_valid), 64'd0);
    push_bundle({32'h37, 32'h36, 32'h35, 32'h34, 32'h33, 32'h32, 32'h31, 32'h30});
    send_frame(32'h30, 8);
    repeat (2) @(negedge clk);

    // Short frame 0xA,0xB,0xC
`ifdef EXPR_LOADER_ZERO_FILL_EN
    push_bundle({32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hC, 32'hB, 32'hA});
`else
    push_err(K_SHORT);
`endif
    send_frame(32'hA, 3);
    repeat (2) @(negedge clk);
    push_bundle({32'h47, 32'h46, 32'h45, 32'h44, 32'h43, 32'h42, 32'h41, 32'h40});
    send_frame(32'h40, 8);
    repeat (2) @(negedge clk);

    // Reset after beat 4, then a fresh frame
    for (int i = 0; i < 5; i++) send(32'h60 + W'(i), 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd0);
    check("arst_X", 64'(X), 64'd0);
    check("arst_Q", 64'(Q), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_bundle({32'h57, 32'h56, 32'h55, 32'h54, 32'h53, 32'h52, 32'h51, 32'h50});
    send_frame(32'h50, 8);

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
